uart_rx: RTL and testbench

UART receiver that recovers the bit timing itself from the serial input line. It pairs with the transmit-side baud timing in the UART bring-up design. It receives 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit), samples each bit at its midpoint, and presents each received byte with a one-cycle valid strobe. It reports a framing error when the stop bit is low.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver, mid-bit sampling, framing-error reporting
// Revision: 1.0
// ============================================================================
module uart_rx #(
   parameter int BR   = 0,
   parameter int CLKF = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int CPB  = (BR > 0 && CLKF >= BR) ? CLKF / BR : 4;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam logic [CW-1:0] C_LAST    = CW'(CPB - 1);
   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);

   if (BR == 0 || CLKF == 0) begin : g_chk_zero
      $fatal(1, "uart_rx: BR and CLKF must both be non-zero");
   end else if (CLKF % BR != 0) begin : g_chk_div
      $fatal(1, "uart_rx: CLKF must be an integer multiple of BR");
   end else if (CLKF / BR < 4) begin : g_chk_ratio
      $fatal(1, "uart_rx: CLKF/BR must be at least 4");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [1:0]    sync;
   logic          rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n, ferr_n;

   assign rx_s = sync[1];
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= 2'b11;
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync      <= {sync[0], rx};
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            // A start bit that is gone by mid-bit was a glitch
            if (cnt == C_HALF_M1) begin
               if (!rx_s) begin
                  state_n = DATA;
                  cnt_n   = '0;
                  idx_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == C_LAST) begin
               shreg_n = {rx_s, shreg[7:1]};
               cnt_n   = '0;
               idx_n   = idx + 1'b1;
               if (idx == 3'd7) begin
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == C_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BREAK: begin
            // Hold off until the line idles so a stuck-low line yields one error
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : directed + randomized frames checked against a byte-queue model.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int last_valid_cyc = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   uart_rx #(.BR(100), .CLKF(1600)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         rx_q.push_back(data);
         last_valid_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (valid || frame_err) begin
         checks++;
         assert (!(valid && frame_err)) else begin
            errors++;
            $error("FAIL pulse_overlap: observed valid=%0b frame_err=%0b expected not both", valid, frame_err);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int p, input logic stop_v, input int stop_len);
      rx = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(p);
      end
      rx = stop_v;
      tick(stop_len);
   endtask

   task automatic check_q(input string tag);
      chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int fall;
      int lat;
      logic [7:0] b;
      int gap;

      // Reset state and quiet idle line
      reset = 1'b1;
      rx    = 1'b1;
      tick(2);
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      tick(200);
      check_q("idle");
      chk("idle_fe", 32'(fe_cnt), 32'h0);

      // Single frame and its latency from the rx fall
      fall = cyc;
      send_frame(8'hA5, 16, 1'b1, 16);
      exp_q.push_back(8'hA5);
      tick(10);
      lat = last_valid_cyc - fall;
      chk("single_latency_ok", 32'(lat >= 154 && lat <= 155), 32'h1);
      chk("single_data", 32'(data), 32'hA5);
      check_q("single");
      chk("single_fe", 32'(fe_cnt), 32'h0);

      // Glitch: short low pulse must not start a frame
      rx = 1'b0;
      tick(4);
      chk("glitch_busy_high", 32'(busy), 32'h1);
      rx = 1'b1;
      tick(8);
      chk("glitch_busy_low", 32'(busy), 32'h0);
      tick(30);
      check_q("glitch");
      chk("glitch_fe", 32'(fe_cnt), 32'h0);

      // Framing error with a long low stop, then recovery
      send_frame(8'hA5, 16, 1'b1, 16);
      exp_q.push_back(8'hA5);
      tick(5);
      send_frame(8'h3C, 16, 1'b0, 40);
      chk("ferr_busy_held", 32'(busy), 32'h1);
      rx = 1'b1;
      tick(5);
      chk("ferr_busy_release", 32'(busy), 32'h0);
      chk("ferr_count", 32'(fe_cnt), 32'h1);
      chk("ferr_data_kept", 32'(data), 32'hA5);
      check_q("ferr");
      fe_cnt = 0;
      send_frame(8'h5A, 16, 1'b1, 16);
      exp_q.push_back(8'h5A);
      tick(10);
      check_q("post_ferr");
      chk("post_ferr_fe", 32'(fe_cnt), 32'h0);

      // Back-to-back frames, last one with a stretched bit period
      send_frame(8'h00, 16, 1'b1, 16);
      send_frame(8'hFF, 16, 1'b1, 16);
      send_frame(8'h81, 17, 1'b1, 17);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h81);
      tick(20);
      check_q("b2b");
      chk("b2b_fe", 32'(fe_cnt), 32'h0);

      // Randomized bytes with random idle gaps
      for (int n = 0; n < 6; n++) begin
         b   = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 6);
         send_frame(b, 16, 1'b1, 16);
         exp_q.push_back(b);
         tick(gap);
      end
      tick(20);
      check_q("rand");
      chk("rand_fe", 32'(fe_cnt), 32'h0);

      // Reset during data bit 4 discards the partial byte
      rx = 1'b0;
      tick(16);
      b = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         tick(16);
      end
      rx = b[4];
      tick(8);
      reset = 1'b1;
      tick(1);
      chk("midrst_data", 32'(data), 32'h00);
      chk("midrst_valid", 32'(valid), 32'h0);
      chk("midrst_ferr", 32'(frame_err), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      rx    = 1'b1;
      tick(200);
      check_q("midrst");
      send_frame(8'h96, 16, 1'b1, 16);
      exp_q.push_back(8'h96);
      tick(10);
      check_q("after_rst");
      chk("after_rst_data", 32'(data), 32'h96);
      chk("after_rst_fe", 32'(fe_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
